// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC and keeps one request in flight to instruction memory.
// Delivers each returned instruction with its PC to IF/ID. Redirects override stalls.
module fetch_pc_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  pc_plus4
);

  typedef enum logic [1:0] {StBoot, StReq, StWait, StHold} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic                 kill_q, kill_d;
  logic [INSTR_W-1:0]   hold_q, hold_d;
  logic                 if_valid_q, if_valid_d;
  logic [ADDR_W-1:0]    if_pc_q, if_pc_d;
  logic [INSTR_W-1:0]   if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]    redirect_tgt;

  assign redirect_tgt = redirect_pc & ~ADDR_W'(3);
  assign pc_plus4     = pc_q + ADDR_W'(4);
  assign imem_addr    = pc_q;
  assign imem_req     = (state_q == StReq);
  assign if_valid     = if_valid_q;
  assign if_pc        = if_pc_q;
  assign if_instr     = if_instr_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    hold_d     = hold_q;
    if_valid_d = 1'b0;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    case (state_q)
      StBoot: state_d = StReq;

      StReq: begin
        if (redirect_valid) pc_d = redirect_tgt;
        if (imem_gnt) begin
          state_d = StWait;
          // The granted request was for the old PC; its response must be dropped.
          kill_d  = redirect_valid;
        end
      end

      StWait: begin
        if (!imem_rvalid) begin
          if (redirect_valid) begin
            pc_d   = redirect_tgt;
            kill_d = 1'b1;
          end
        end else begin
          state_d = StReq;
          if (kill_q) begin
            kill_d = 1'b0;
            if (redirect_valid) pc_d = redirect_tgt;
          end else if (redirect_valid) begin
            pc_d = redirect_tgt;
          end else if (!stall) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata;
            pc_d       = pc_plus4;
          end else begin
            hold_d  = imem_rdata;
            state_d = StHold;
          end
        end
      end

      StHold: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = StReq;
        end else if (!stall) begin
          // pc is unchanged while holding, so it is still the held instruction's PC.
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_instr_d = hold_q;
          pc_d       = pc_plus4;
          state_d    = StReq;
        end
      end

      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      hold_q     <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      hold_q     <= hold_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end; owns the program counter.
- Issues one outstanding request at a time to instruction memory.
- Delivers each returned instruction and its PC to the IF/ID pipeline register.
- Exports pc_plus4, which is the sequential input of the downstream next-PC 2:1 select; the select's output returns here as redirect_pc.

Parameters:
ADDR_W, 32, PC and memory address width
INSTR_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded at reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  IF/ID cannot accept an instruction this cycle
redirect_valid  in  1  branch/jump taken; load redirect_pc
redirect_pc  in  ADDR_W  target PC from next-PC select
imem_req  out  1  memory request valid
imem_addr  out  ADDR_W  request address (= pc register)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  INSTR_W  read data
if_valid  out  1  registered one-cycle pulse: instruction delivered
if_pc  out  ADDR_W  PC of delivered instruction
if_instr  out  INSTR_W  delivered instruction
pc_plus4  out  ADDR_W  combinational pc+4, to next-PC select

Behaviour:
- Reset (async assert, sync release): state=BOOT, pc=RESET_PC, kill=0, hold buffer cleared.
- Output reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=RESET_PC, if_instr=0.
- Reset mid-transaction: abandon the transaction; any late imem_rvalid is ignored until state reaches WAIT again.
- Arithmetic: pc+4 is modulo 2^ADDR_W; 0xFFFF_FFFC wraps to 0x0000_0000.
- Redirect address: low 2 bits forced to 00.
- imem_addr = pc register.
- imem_req=1 only in state REQ.
- BOOT: imem_req=0 -> REQ next cycle. redirect_valid is ignored in BOOT.
- REQ, no grant:
  - Redirect: pc<=redirect, stay REQ.
  - No redirect: stay REQ with address held stable.
- REQ, gnt=1:
  - No redirect: -> WAIT.
  - Redirect in the same cycle: pc<=redirect, kill<=1, -> WAIT.
- WAIT, rvalid=0:
  - Redirect: pc<=redirect, kill<=1.
  - No redirect: stay.
- WAIT, rvalid=1, response handling in priority order:
  - kill=1: discard, kill<=0, -> REQ.
  - redirect_valid: discard, pc<=redirect, -> REQ.
  - stall=0: if_valid<=1, if_pc<=pc, if_instr<=rdata, pc<=pc+4, -> REQ.
  - stall=1: store rdata/pc in hold buffer, -> HOLD.
- HOLD:
  - Redirect: drop buffer, pc<=redirect, -> REQ.
  - stall=0: deliver buffered instruction (if_valid<=1), pc<=pc+4, -> REQ.
  - stall=1: stay.
- Priority everywhere: redirect_valid over stall.
- if_valid is never asserted in the cycle following a cycle with redirect_valid=1.
- if_valid is high for exactly one cycle per delivery; if_pc/if_instr hold their last values otherwise.
- rvalid outside WAIT is ignored.
- Throughput: zero-latency memory (gnt in REQ, rvalid the next cycle) gives one delivery per 2 cycles.

Test Plan:
- Reset release, memory always grants, rvalid one cycle after gnt, no stall -> first imem_addr=0x0; if_valid pulses every 2 cycles with if_pc 0x0, 0x4, 0x8.
- stall held high for 3 cycles when rvalid returns instr 0x1234_5678 at PC 0x8 -> no if_valid during stall; one pulse with if_pc=0x8, if_instr=0x1234_5678 the cycle after stall drops; next imem_addr=0xC.
- redirect_valid with redirect_pc=0x103 while in WAIT -> in-flight response discarded, no if_valid; next imem_addr=0x100; first delivered if_pc=0x100.
- redirect_valid same cycle as gnt, and separately same cycle as rvalid with stall=1 -> both responses dropped; redirect target fetched next; no stray if_valid.
- pc=0xFFFF_FFFC delivered -> next imem_addr=0x0000_0000, pc_plus4 shows 0x0 while pc=0xFFFF_FFFC.
- rst_n asserted in WAIT while rvalid pending -> all outputs at reset values immediately; after release, refetch from RESET_PC.
